// File: rtl/neopix_encoder_pkg.sv
// rtl/neopix_encoder_pkg.sv - shared types and 50 MHz timing defaults for the neopixel encoder
package neopix_pkg;

   // Encoder FSM states; LATCH is also the reset state so every power-up drives a clean strip reset
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   // Pixel word width, GRB with bit 23 first; also used by spi_to_neopix
   localparam int PIX_W = 24;

   // Default timing for a 50 MHz clock
   localparam int DEF_NUM_LEDS  = 8;
   localparam int DEF_T0H_CYC   = 20;
   localparam int DEF_T1H_CYC   = 40;
   localparam int DEF_BIT_CYC   = 63;
   localparam int DEF_RESET_CYC = 15000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/neopix_encoder_if.sv
// rtl/neopix_encoder_if.sv - pixel word valid/ready handshake between pixel source and encoder
interface neopix_encoder_if;
   import neopix_pkg::*;

   logic [PIX_W-1:0] pix_data;
   logic             pix_valid;
   logic             pix_ready;

   modport master (
      output pix_data,
      output pix_valid,
      input  pix_ready
   );

   modport slave (
      input  pix_data,
      input  pix_valid,
      output pix_ready
   );

endinterface

// File: rtl/neopix_encoder.sv
// rtl/neopix_encoder.sv - WS2812-class single-wire waveform generator with frame latch gap
module neopix_encoder
   import neopix_pkg::*;
#(
   parameter int NUM_LEDS  = DEF_NUM_LEDS,
   parameter int T0H_CYC   = DEF_T0H_CYC,
   parameter int T1H_CYC   = DEF_T1H_CYC,
   parameter int BIT_CYC   = DEF_BIT_CYC,
   parameter int RESET_CYC = DEF_RESET_CYC
) (
   input  logic           clk,
   input  logic           rst_n,
   neopix_encoder_if.slave pix,
   output logic           dout,
   output logic           busy,
   output logic           frame_done,
   output logic           underrun
);

   localparam int CW  = $clog2(max_int(BIT_CYC, RESET_CYC));
   localparam int PCW = $clog2(NUM_LEDS + 1);

   localparam logic [CW-1:0]  T0H_LAST   = CW'(T0H_CYC - 1);
   localparam logic [CW-1:0]  T1H_LAST   = CW'(T1H_CYC - 1);
   localparam logic [CW-1:0]  BIT_LAST   = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0]  RESET_LAST = CW'(RESET_CYC - 1);
   localparam logic [PCW-1:0] PIX_LAST   = PCW'(NUM_LEDS - 1);
   localparam logic [4:0]     TOP_BIT    = 5'(PIX_W - 1);

   if (NUM_LEDS < 1) begin : g_bad_num_leds
      $error("NUM_LEDS must be at least 1");
   end
   if (T0H_CYC < 1) begin : g_bad_t0h
      $error("T0H_CYC must be at least 1");
   end
   if (!((T0H_CYC < T1H_CYC) && (T1H_CYC < BIT_CYC))) begin : g_bad_order
      $error("timing must satisfy T0H_CYC < T1H_CYC < BIT_CYC");
   end
   if (RESET_CYC < 1) begin : g_bad_reset
      $error("RESET_CYC must be at least 1");
   end

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [4:0]       idx, idx_n;
   logic [PIX_W-1:0] shreg, shreg_n;
   logic [PCW-1:0]   pcnt, pcnt_n;
   logic             dout_n;
   logic             fd_n;
   logic             ur_n;
   logic             ready;

   assign pix.pix_ready = ready;
   assign busy          = (state != ST_IDLE);

   // Registers for FSM and datapath; async reset drops DO at once and restarts with a full latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_LATCH;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         pcnt       <= '0;
         dout       <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         shreg      <= shreg_n;
         pcnt       <= pcnt_n;
         dout       <= dout_n;
         frame_done <= fd_n;
         underrun   <= ur_n;
      end
   end

   // Next-state logic: the cycle counter runs across a whole bit slot, HIGH ends at TxH-1, LOW at BIT-1
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      idx_n   = idx;
      shreg_n = shreg;
      pcnt_n  = pcnt;
      fd_n    = 1'b0;
      ur_n    = 1'b0;
      ready   = 1'b0;

      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            cnt_n = '0;
            if (pix.pix_valid) begin
               shreg_n = pix.pix_data;
               idx_n   = TOP_BIT;
               pcnt_n  = '0;
               state_n = ST_HIGH;
            end
         end

         ST_HIGH: begin
            if (cnt == (shreg[PIX_W-1] ? T1H_LAST : T0H_LAST)) begin
               state_n = ST_LOW;
            end
         end

         ST_LOW: begin
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               if (idx != 5'd0) begin
                  shreg_n = {shreg[PIX_W-2:0], 1'b0};
                  idx_n   = idx - 5'd1;
                  state_n = ST_HIGH;
               end else if (pcnt < PIX_LAST) begin
                  // Gapless hand-off: the next pixel may be taken in the last cycle of this one
                  ready = 1'b1;
                  if (pix.pix_valid) begin
                     shreg_n = pix.pix_data;
                     idx_n   = TOP_BIT;
                     pcnt_n  = pcnt + PCW'(1);
                     state_n = ST_HIGH;
                  end else begin
                     ur_n    = 1'b1;
                     pcnt_n  = '0;
                     state_n = ST_LATCH;
                  end
               end else begin
                  pcnt_n  = '0;
                  state_n = ST_LATCH;
               end
            end
         end

         ST_LATCH: begin
            pcnt_n = '0;
            if (cnt == RESET_LAST) begin
               fd_n    = 1'b1;
               cnt_n   = '0;
               state_n = ST_IDLE;
            end
         end

         default: begin
            cnt_n   = '0;
            state_n = ST_LATCH;
         end
      endcase

      // DO is registered so it lines up with the state it belongs to
      dout_n = (state_n == ST_HIGH);
   end

endmodule

// File: tb/tb_neopix_encoder.sv
// tb/tb_neopix_encoder.sv - directed vector bench for neopix_encoder
module tb_neopix_encoder;
   import neopix_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dout, busy, frame_done, underrun;

   neopix_encoder_if pif ();

   neopix_encoder #(
      .NUM_LEDS  (2),
      .T0H_CYC   (2),
      .T1H_CYC   (4),
      .BIT_CYC   (6),
      .RESET_CYC (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix        (pif.slave),
      .dout       (dout),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        valid;
      logic [23:0] data;
      logic        e_do;
      logic        e_rdy;
      logic        e_busy;
      logic        e_fd;
      logic        e_ur;
   } vec_t;

   vec_t tbl[$];
   int   total  = 0;
   int   passed = 0;
   int   cyc    = 0;
   int   fd_cyc = 0;
   int   start_cyc = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_outs(input string nm, input logic o, input logic r, input logic b,
                             input logic f, input logic u);
      chk1({nm, ".do"}, dout, o);
      chk1({nm, ".ready"}, pif.pix_ready, r);
      chk1({nm, ".busy"}, busy, b);
      chk1({nm, ".frame_done"}, frame_done, f);
      chk1({nm, ".underrun"}, underrun, u);
   endtask

   task automatic add(input string nm, input int n, input logic v, input logic [23:0] d,
                      input logic o, input logic r, input logic b, input logic f, input logic u);
      repeat (n) tbl.push_back('{name: nm, valid: v, data: d, e_do: o, e_rdy: r,
                                 e_busy: b, e_fd: f, e_ur: u});
   endtask

   // Expected DO per slot: bit 1 -> 4 high of 6, bit 0 -> 2 high of 6; READY only in the final cycle
   task automatic run_pixel(input logic [23:0] px, input int top, input logic hold_v,
                            input logic end_rdy, input logic nv, input logic [23:0] nd,
                            input string nm);
      for (int b = top; b >= 0; b--) begin
         for (int c = 0; c < 6; c++) begin
            logic last;
            int   hi;
            last = (b == 0) && (c == 5);
            hi   = px[b] ? 4 : 2;
            if (last) begin
               pif.pix_valid = nv;
               pif.pix_data  = nd;
            end else begin
               pif.pix_valid = hold_v;
               pif.pix_data  = 24'($urandom());
            end
            chk1({nm, ".do"}, dout, (c < hi));
            chk1({nm, ".ready"}, pif.pix_ready, last ? end_rdy : 1'b0);
            step();
         end
      end
   endtask

   // Ten latch cycles with DO low, then the FRAME_DONE cycle, which is already IDLE
   task automatic run_latch(input logic exp_ur, input logic lv, input logic nv,
                            input logic [23:0] nd, input string nm);
      for (int k = 0; k < 10; k++) begin
         pif.pix_valid = lv;
         pif.pix_data  = 24'($urandom());
         check_outs(nm, 1'b0, 1'b0, 1'b1, 1'b0, (k == 0) ? exp_ur : 1'b0);
         step();
      end
      pif.pix_valid = nv;
      pif.pix_data  = nd;
      fd_cyc = cyc;
      check_outs({nm, "_end"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
   endtask

   initial begin
      pif.pix_valid = 1'b0;
      pif.pix_data  = '0;
      rst_n         = 1'b0;
      repeat (3) @(negedge clk);
      check_outs("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset release latch (VALID high ignored), FRAME_DONE, then pixel A00000 first two slots
      add("rel_latch",  10, 1'b1, 24'h5A5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add("rel_done",    1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      add("idle_xfer",   1, 1'b1, 24'hA00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add("b23_high",    4, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      add("b23_low",     2, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add("b22_high",    2, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      add("b22_low",     4, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      rst_n = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         pif.pix_valid = tbl[i].valid;
         pif.pix_data  = tbl[i].data;
         check_outs(tbl[i].name, tbl[i].e_do, tbl[i].e_rdy, tbl[i].e_busy,
                    tbl[i].e_fd, tbl[i].e_ur);
         step();
      end

      // Rest of A00000 with VALID withheld at the boundary -> underrun and latch
      run_pixel(24'hA00000, 21, 1'b0, 1'b1, 1'b0, 24'h000000, "pxA");
      run_latch(1'b1, 1'b1, 1'b1, 24'hFFFFFF, "ur_latch");

      // Two-pixel frame with VALID held high throughout
      start_cyc = cyc;
      run_pixel(24'hFFFFFF, 23, 1'b1, 1'b1, 1'b1, 24'h000000, "px0");
      run_pixel(24'h000000, 23, 1'b1, 1'b0, 1'b1, 24'h123456, "px1");
      run_latch(1'b0, 1'b1, 1'b1, 24'hFFFFFF, "frame_latch");
      chk_int("frame_len", fd_cyc - start_cyc, 298);

      // Reset asserted in the middle of a HIGH phase
      chk1("rst_pre.do0", dout, 1'b1);
      step();
      chk1("rst_pre.do1", dout, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk1("rst_async.do", dout, 1'b0);
      chk1("rst_async.ready", pif.pix_ready, 1'b0);
      chk1("rst_async.busy", busy, 1'b1);
      pif.pix_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_latch(1'b0, 1'b1, 1'b0, 24'h000000, "rst_latch");
      check_outs("idle_after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check_outs("idle_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
